// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI-slave memory bridge.
// Holds the controller state encoding and the byte/edge-detect constants.
package spi_mem_pkg;

  localparam int BYTE_W = 8;

  // Level the rx-valid edge detector assumes before the first byte.
  localparam logic RX_IDLE_LVL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WR_DATA,
    S_WR_REQ,
    S_RD_REQ,
    S_TX_WAIT,
    S_TX_HOLD
  } state_e;

endpackage

// File: rtl/spi_byte_strobe.sv
// Turns the level-style rx-valid from the SPI receiver into a one-cycle strobe
// per received byte (rising-edge detect).
module spi_byte_strobe
  import spi_mem_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx_valid,
  output logic o_rx_stb
);

  logic rx_valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rx_valid_q <= RX_IDLE_LVL;
    else          rx_valid_q <= i_rx_valid;
  end

  assign o_rx_stb = i_rx_valid & ~rx_valid_q;

endmodule

// File: rtl/spi_mem_bridge_ctrl.sv
// SPI-slave command controller: decodes an address header (MSB = write flag) and
// streams auto-incrementing words between the SPI byte interface and memory.
module spi_mem_bridge_ctrl
  import spi_mem_pkg::*;
#(
  parameter  int ADDR_BYTES = 2,
  parameter  int DATA_BYTES = 2,
  parameter  int RD_STEP    = 1,
  parameter  int WR_STEP    = 1,
  localparam int ADDR_W     = 8*ADDR_BYTES-1,
  localparam int DATA_W     = 8*DATA_BYTES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_load,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_busy
);

  localparam int HDR_W = BYTE_W*ADDR_BYTES;
  localparam int MAX_B = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W = $clog2(MAX_B) + 1;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_BYTES-1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES-1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HDR_W-BYTE_W-1:0] hdr_q, hdr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     txsh_q, txsh_d;
  logic [HDR_W-1:0]      hdr_full;
  logic                  rx_stb;

  spi_byte_strobe u_stb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_valid (i_rx_valid),
    .o_rx_stb   (rx_stb)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txsh_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txsh_q  <= txsh_d;
    end
  end

  // Header bytes arrive MSB first, so the newest byte lands at the bottom.
  assign hdr_full = {hdr_q, i_rx_byte};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txsh_d    = txsh_q;
    o_mem_we  = 1'b0;
    o_mem_re  = 1'b0;
    o_tx_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_cs) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        if (rx_stb) begin
          hdr_d = hdr_full[HDR_W-BYTE_W-1:0];
          if (cnt_q == HDR_LAST) begin
            addr_d  = hdr_full[ADDR_W-1:0];
            cnt_d   = '0;
            state_d = hdr_full[HDR_W-1] ? S_WR_DATA : S_RD_REQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WR_DATA: begin
        if (rx_stb) begin
          for (int b = 0; b < DATA_BYTES; b++)
            if (cnt_q == CNT_W'(b)) wdata_d[BYTE_W*b +: BYTE_W] = i_rx_byte;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_WR_REQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        // Bytes strobed here are dropped: the host overran the memory.
        o_mem_we = 1'b1;
        if (i_mem_ack) begin
          addr_d  = addr_q + ADDR_W'(WR_STEP);
          cnt_d   = '0;
          state_d = S_WR_DATA;
        end
      end
      S_RD_REQ: begin
        o_mem_re = 1'b1;
        if (i_mem_ack) begin
          txsh_d  = i_mem_rdata;
          cnt_d   = '0;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (i_tx_ready) begin
          o_tx_load = 1'b1;
          state_d   = S_TX_HOLD;
        end
      end
      S_TX_HOLD: begin
        // Wait for the transmitter to take the byte before moving on.
        if (!i_tx_ready) begin
          if (cnt_q == DATA_LAST) begin
            addr_d  = addr_q + ADDR_W'(RD_STEP);
            state_d = S_RD_REQ;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_TX_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Deselect aborts the frame from any state; a write acked this cycle still lands.
    if (i_cs) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    o_tx_byte = '0;
    for (int b = 0; b < DATA_BYTES; b++)
      if (cnt_q == CNT_W'(b)) o_tx_byte = txsh_q[BYTE_W*b +: BYTE_W];
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_mem_bridge_ctrl.sv
// Bench for spi_mem_bridge_ctrl: randomized frames against a word/byte-stream
// model of the SPI protocol, plus directed literal checks and a wide-parameter instance.
module tb_spi_mem_bridge_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b1, cs2 = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0, tx_ready = 1'b1;
  logic        mem_ack = 1'b0, ack2 = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [31:0] rdata2 = '0;

  logic [7:0]  tx_byte, tx_byte2;
  logic        tx_load, we, re, busy, tx_load2, we2, re2, busy2;
  logic [14:0] mem_addr;
  logic [15:0] wdata;
  logic [22:0] addr2;
  logic [31:0] wdata2;

  always #5 clk = ~clk;

  spi_mem_bridge_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .i_tx_ready(tx_ready), .o_tx_byte(tx_byte), .o_tx_load(tx_load), .o_mem_addr(mem_addr),
    .o_mem_wdata(wdata), .o_mem_we(we), .o_mem_re(re), .i_mem_rdata(mem_rdata),
    .i_mem_ack(mem_ack), .o_busy(busy)
  );

  spi_mem_bridge_ctrl #(.ADDR_BYTES(3), .DATA_BYTES(4), .WR_STEP(4)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs2), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .i_tx_ready(tx_ready), .o_tx_byte(tx_byte2), .o_tx_load(tx_load2), .o_mem_addr(addr2),
    .o_mem_wdata(wdata2), .o_mem_we(we2), .o_mem_re(re2), .i_mem_rdata(rdata2),
    .i_mem_ack(ack2), .o_busy(busy2)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model state: memory, expected write words, read-stream origin.
  typedef struct packed { logic [14:0] a; logic [15:0] d; } wr_t;
  logic [15:0] mem [0:32767];
  wr_t         exp_wr[$];
  logic [7:0]  dq[$];
  logic [14:0] wr_a_log[$], rd_a_log[$];
  logic [15:0] wr_d_log[$];
  logic [7:0]  tx_log[$];
  logic [22:0] a2_log[$];
  logic [31:0] d2_log[$];
  bit          rd_active = 0, ack_en = 1, prev_pend = 0;
  logic [14:0] rd_base = '0, prev_addr = '0;
  logic [15:0] prev_wdata = '0;
  int          rd_k = 0, tx_k = 0, wr_cnt = 0, txb = 0, dly = 0;

  // Compare process: every memory handshake and tx load checked against the model.
  always @(negedge clk) begin : cmp
    logic [14:0] ea;
    logic [15:0] mw;
    wr_t         e;
    if (!rst_n) begin
      prev_pend = 0;
    end else begin
      if (we | re) check("we_re_exclusive", 32'(we & re), 32'(0));
      if ((we | re) && prev_pend) begin
        check("addr_stable", 32'(mem_addr), 32'(prev_addr));
        if (we) check("wdata_stable", 32'(wdata), 32'(prev_wdata));
      end
      if (we && mem_ack) begin
        wr_cnt++;
        wr_a_log.push_back(mem_addr);
        wr_d_log.push_back(wdata);
        mem[mem_addr] = wdata;
        check("wr_expected", 32'(exp_wr.size() > 0), 32'(1));
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.a));
          check("wr_data", 32'(wdata), 32'(e.d));
        end
      end
      if (re && mem_ack) begin
        rd_a_log.push_back(mem_addr);
        check("rd_in_read_frame", 32'(rd_active), 32'(1));
        ea = rd_base + 15'(rd_k);
        check("rd_addr", 32'(mem_addr), 32'(ea));
        rd_k++;
      end
      if (tx_load) begin
        tx_log.push_back(tx_byte);
        check("tx_in_read_frame", 32'(rd_active), 32'(1));
        ea = rd_base + 15'(tx_k / 2);
        mw = mem[ea];
        check("tx_byte", 32'(tx_byte), (tx_k % 2 == 1) ? 32'(mw[15:8]) : 32'(mw[7:0]));
        tx_k++;
        txb = $urandom_range(1, 4);
      end
      if (we | re | tx_load) check("busy_when_active", 32'(busy), 32'(1));
      prev_pend  = (we | re) & ~mem_ack;
      prev_addr  = mem_addr;
      prev_wdata = wdata;
      if (we2 && ack2) begin
        a2_log.push_back(addr2);
        d2_log.push_back(wdata2);
      end
    end
  end

  // Memory responder and SPI transmitter model.
  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
    end else if (ack_en && (we || re)) begin
      if (dly == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        dly       = $urandom_range(0, 3);
      end else dly--;
    end else mem_rdata = 16'($urandom);
    ack2 = we2 && !ack2;
    if (txb > 0) begin
      tx_ready = 1'b0;
      txb--;
    end else tx_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    repeat ($urandom_range(0, 1)) @(posedge clk);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(posedge clk);
  endtask

  task automatic start_frame;
    @(posedge clk); #1 cs = 1'b0;
    @(posedge clk);
  endtask

  task automatic end_frame;
    @(posedge clk); #1;
    cs = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_after_cs", 32'(busy), 32'(0));
    rd_active = 0;
  endtask

  task automatic wait_wr(input int prev);
    int t = 0;
    while (wr_cnt == prev && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("wr_done_in_time", 32'(wr_cnt > prev), 32'(1));
  endtask

  task automatic run_write(input logic [14:0] a, input int nb);
    for (int i = 0; i < nb / 2; i++)
      exp_wr.push_back('{a: a + 15'(i), d: {dq[2*i+1], dq[2*i]}});
    start_frame();
    send_byte({1'b1, a[14:8]});
    send_byte(a[7:0]);
    for (int i = 0; i < nb; i++) begin
      int p = wr_cnt;
      send_byte(dq[i]);
      if (i % 2 == 1) wait_wr(p);
    end
    end_frame();
    check("wr_all_seen", 32'(exp_wr.size()), 32'(0));
    exp_wr.delete();
  endtask

  task automatic run_read(input logic [14:0] a, input int n);
    int t = 0;
    rd_base = a; rd_k = 0; tx_k = 0; rd_active = 1;
    start_frame();
    send_byte({1'b0, a[14:8]});
    send_byte(a[7:0]);
    while (tx_k < n && t < 1000) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) begin
        rx_valid = ~rx_valid;
        if (rx_valid) rx_byte = 8'($urandom);
      end
      t++;
    end
    check("rd_tx_count", 32'(tx_k >= n), 32'(1));
    end_frame();
  endtask

  task automatic clear_logs;
    wr_a_log.delete(); wr_d_log.delete(); rd_a_log.delete(); tx_log.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({we, re, tx_load, busy}), 32'(0));
    check({tag, "_txbyte"}, 32'(tx_byte), 32'(0));
    check({tag, "_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_wdata"}, 32'(wdata), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b2 [8];
    int t;
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
    #3 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write burst with literal expectations.
    clear_logs();
    dq = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_write(15'h0010, 4);
    check("wb_count", 32'(wr_a_log.size()), 32'(2));
    if (wr_a_log.size() == 2) begin
      check("wb_addr0", 32'(wr_a_log[0]), 32'h0010);
      check("wb_data0", 32'(wr_d_log[0]), 32'h1234);
      check("wb_addr1", 32'(wr_a_log[1]), 32'h0011);
      check("wb_data1", 32'(wr_d_log[1]), 32'h5678);
    end

    // Read burst with literal expectations.
    clear_logs();
    mem[15'h0020] = 16'hBEEF;
    mem[15'h0021] = 16'hCAFE;
    run_read(15'h0020, 4);
    if (tx_log.size() >= 4) begin
      check("rb_tx0", 32'(tx_log[0]), 32'hEF);
      check("rb_tx1", 32'(tx_log[1]), 32'hBE);
      check("rb_tx2", 32'(tx_log[2]), 32'hFE);
      check("rb_tx3", 32'(tx_log[3]), 32'hCA);
    end
    if (rd_a_log.size() >= 2) begin
      check("rb_addr0", 32'(rd_a_log[0]), 32'h0020);
      check("rb_addr1", 32'(rd_a_log[1]), 32'h0021);
    end

    // Address wrap on read.
    clear_logs();
    run_read(15'h7FFF, 4);
    check("wrap_reads", 32'(rd_a_log.size() >= 2), 32'(1));
    if (rd_a_log.size() >= 2) check("wrap_addr1", 32'(rd_a_log[1]), 32'h0000);

    // Abort after the first data byte of a write.
    clear_logs();
    start_frame();
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h99);
    @(posedge clk); #1 cs = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_we", 32'(we), 32'(0));
    repeat (4) @(posedge clk);
    check("abort_no_write", 32'(wr_a_log.size()), 32'(0));

    // Reset while a write request is pending.
    ack_en = 0;
    start_frame();
    send_byte(8'h80); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    t = 0;
    while (!we && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    check("rstw_we_pending", 32'(we), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("rstw");
    cs = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    check("rstw_idle0", 32'(busy), 32'(0));
    @(posedge clk); #1;
    check("rstw_idle1", 32'(busy), 32'(0));
    check("rstw_no_write", 32'(wr_a_log.size()), 32'(0));
    ack_en = 1;

    // Randomized frames.
    repeat (24) begin
      logic [14:0] a;
      a = ($urandom_range(0, 3) == 0) ? 15'h7FFC + 15'($urandom_range(0, 3)) : 15'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        int nb = 2 * $urandom_range(1, 4) + $urandom_range(0, 1);
        dq.delete();
        for (int i = 0; i < nb; i++) dq.push_back(8'($urandom));
        run_write(a, nb);
      end else begin
        run_read(a, $urandom_range(1, 7));
      end
    end

    // Wide instance: 3 header bytes, 4-byte words, write step 4.
    b2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    @(posedge clk); #1 cs2 = 1'b0;
    @(posedge clk);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h08);
    for (int i = 0; i < 8; i++) begin
      send_byte(b2[i]);
      if (i % 4 == 3) repeat (4) @(posedge clk);
    end
    @(posedge clk); #1 cs2 = 1'b1;
    @(posedge clk); #1;
    check("w2_busy", 32'(busy2), 32'(0));
    check("w2_count", 32'(a2_log.size()), 32'(2));
    if (a2_log.size() == 2) begin
      check("w2_addr0", 32'(a2_log[0]), 32'h000008);
      check("w2_data0", d2_log[0], 32'h44332211);
      check("w2_addr1", 32'(a2_log[1]), 32'h00000C);
      check("w2_data1", d2_log[1], 32'h88776655);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
